// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline control logic (master) and the
// program-counter unit (slave).
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             exc_req;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             fetch_valid;
  logic             in_delay_slot;
  logic [WIDTH-1:0] epc;
  logic             epc_bd;
  logic [WIDTH-1:0] badaddr;
  logic             misalign_fault;

  modport master (
    output stall, redirect_valid, redirect_target, exc_req, eret,
    input  pc, pc_plus_inc, fetch_valid, in_delay_slot, epc, epc_bd,
           badaddr, misalign_fault
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, exc_req, eret,
    output pc, pc_plus_inc, fetch_valid, in_delay_slot, epc, epc_bd,
           badaddr, misalign_fault
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, stall, redirect (optionally with one
// delay slot), redirects captured under stall, exception vectoring and ERET.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int               DELAY_SLOT   = 0,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  typedef enum logic [1:0] {RUN, PEND, DELAY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             epc_bd_q, epc_bd_d;
  logic [WIDTH-1:0] badaddr_q, badaddr_d;
  logic             fault_q, fault_d;
  logic             ids_q, ids_d;
  logic             fvalid_q;

  logic [WIDTH-1:0] pc_plus;
  logic             misaligned;
  logic             have_redir;
  logic [WIDTH-1:0] redir_tgt;

  assign pc_plus = pc_q + INC_W;
  // A target arriving while the delay slot is fetched is dropped, so it cannot fault either.
  assign misaligned = bus.redirect_valid && ((bus.redirect_target & ALIGN_MASK) != '0)
                      && (state_q != DELAY);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    epc_d      = epc_q;
    epc_bd_d   = epc_bd_q;
    badaddr_d  = badaddr_q;
    fault_d    = 1'b0;
    ids_d      = ids_q;
    have_redir = 1'b0;
    redir_tgt  = bus.redirect_target;

    if (bus.exc_req) begin
      // In the slot, the restart point is the branch itself so it re-executes.
      epc_d    = (state_q == DELAY) ? pc_q - INC_W : pc_q;
      epc_bd_d = (state_q == DELAY);
      pc_d     = EXC_VECTOR;
      pend_d   = '0;
      state_d  = RUN;
      ids_d    = 1'b0;
    end else if (misaligned) begin
      fault_d   = 1'b1;
      badaddr_d = bus.redirect_target;
      epc_d     = pc_q;
      epc_bd_d  = 1'b0;
      pc_d      = EXC_VECTOR;
      pend_d    = '0;
      state_d   = RUN;
      ids_d     = 1'b0;
    end else if (bus.eret) begin
      pc_d    = epc_q;
      pend_d  = '0;
      state_d = RUN;
      ids_d   = 1'b0;
    end else if (bus.stall) begin
      if (bus.redirect_valid && (state_q != DELAY)) begin
        pend_d  = bus.redirect_target;
        state_d = PEND;
      end
    end else if (state_q == DELAY) begin
      pc_d    = pend_q;
      state_d = RUN;
      ids_d   = 1'b0;
    end else begin
      // A fresh redirect in the release cycle supersedes the captured one.
      have_redir = bus.redirect_valid || (state_q == PEND);
      redir_tgt  = bus.redirect_valid ? bus.redirect_target : pend_q;
      if (have_redir && (DELAY_SLOT != 0)) begin
        pc_d    = pc_plus;
        pend_d  = redir_tgt;
        state_d = DELAY;
        ids_d   = 1'b1;
      end else if (have_redir) begin
        pc_d    = redir_tgt;
        state_d = RUN;
        ids_d   = 1'b0;
      end else begin
        pc_d  = pc_plus;
        ids_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      pend_q    <= '0;
      epc_q     <= '0;
      epc_bd_q  <= 1'b0;
      badaddr_q <= '0;
      fault_q   <= 1'b0;
      ids_q     <= 1'b0;
      fvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      epc_q     <= epc_d;
      epc_bd_q  <= epc_bd_d;
      badaddr_q <= badaddr_d;
      fault_q   <= fault_d;
      ids_q     <= ids_d;
      fvalid_q  <= 1'b1;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus_inc    = pc_plus;
  assign bus.fetch_valid    = fvalid_q;
  assign bus.in_delay_slot  = ids_q;
  assign bus.epc            = epc_q;
  assign bus.epc_bd         = epc_bd_q;
  assign bus.badaddr        = badaddr_q;
  assign bus.misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios on three configurations plus a random
// run checked against an architectural model of the PC rules.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, rv, exc, eret;
  logic [31:0] tgt;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) if0 ();
  pc_unit_if #(.WIDTH(32)) if1 ();
  pc_unit_if #(.WIDTH(8))  if2 ();

  assign if0.stall = stall;  assign if0.redirect_valid = rv;  assign if0.redirect_target = tgt;
  assign if0.exc_req = exc;  assign if0.eret = eret;
  assign if1.stall = stall;  assign if1.redirect_valid = rv;  assign if1.redirect_target = tgt;
  assign if1.exc_req = exc;  assign if1.eret = eret;
  assign if2.stall = stall;  assign if2.redirect_valid = rv;  assign if2.redirect_target = tgt[7:0];
  assign if2.exc_req = exc;  assign if2.eret = eret;

  pc_unit #(.WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h8000_0180),
            .DELAY_SLOT(0), .ALIGN_BITS(2)) u0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
  pc_unit #(.WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h8000_0180),
            .DELAY_SLOT(1), .ALIGN_BITS(2)) u1 (.clk(clk), .reset(rst_n), .bus(if1.slave));
  pc_unit #(.WIDTH(8), .INC(4), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80),
            .DELAY_SLOT(0), .ALIGN_BITS(2)) u2 (.clk(clk), .reset(rst_n), .bus(if2.slave));

  // Architectural view: a captured/slot target is "owed" (owe/owed_t); slot marks a delay-slot fetch.
  typedef struct packed {
    logic [31:0] pc, epc, bad, owed_t;
    logic        bd, fault, fv, slot, owe;
  } m_t;

  function automatic m_t m_step(m_t s, bit ds, int w, logic [31:0] exc_vec,
                                bit r, bit st, bit v, logic [31:0] t_in, bit x, bit e);
    logic [31:0] mask;
    logic [31:0] t;
    m_t          n;
    mask    = 32'hFFFF_FFFF >> (32 - w);
    t       = t_in & mask;
    n       = s;
    n.fault = 1'b0;
    if (!r) begin
      n = '0;
      return n;
    end
    n.fv = 1'b1;
    if (x) begin
      n.epc = s.slot ? ((s.pc - 32'd4) & mask) : s.pc;
      n.bd  = s.slot;
      n.pc  = exc_vec;  n.owe = 1'b0;  n.slot = 1'b0;
    end else if (v && (t[1:0] != 2'b00) && !s.slot) begin
      n.fault = 1'b1;  n.bad = t;  n.epc = s.pc;  n.bd = 1'b0;
      n.pc = exc_vec;  n.owe = 1'b0;  n.slot = 1'b0;
    end else if (e) begin
      n.pc = s.epc;  n.owe = 1'b0;  n.slot = 1'b0;
    end else if (st) begin
      if (v && !s.slot) begin n.owe = 1'b1; n.owed_t = t; end
    end else if (s.slot) begin
      n.pc = s.owed_t;  n.slot = 1'b0;  n.owe = 1'b0;
    end else if (v || s.owe) begin
      if (ds) begin
        n.pc = (s.pc + 32'd4) & mask;  n.owed_t = v ? t : s.owed_t;  n.owe = 1'b1;  n.slot = 1'b1;
      end else begin
        n.pc = v ? t : s.owed_t;  n.owe = 1'b0;
      end
    end else begin
      n.pc = (s.pc + 32'd4) & mask;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; rv = 1'b0; tgt = 32'h0; exc = 1'b0; eret = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    n_tests++; if (if0.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", if0.pc, 32'h0); end
    n_tests++; if (if0.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got=%b exp=0", if0.fetch_valid); end
    n_tests++; if (if0.epc !== 32'h0 || if0.badaddr !== 32'h0) begin n_fail++; $display("FAIL reset_epc_bad got=%h/%h exp=0/0", if0.epc, if0.badaddr); end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_pc = 32'(4 * i);
      n_tests++; if (if0.pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, if0.pc, exp_pc); end
      n_tests++; if (if0.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv%0d got=%b exp=1", i, if0.fetch_valid); end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    steps(4);
    stall = 1'b1; rv = 1'b1; tgt = 32'h100;
    step();
    n_tests++; if (if0.pc !== 32'h10) begin n_fail++; $display("FAIL stall_hold1 got=%h exp=%h", if0.pc, 32'h10); end
    tgt = 32'h200;
    step();
    n_tests++; if (if0.pc !== 32'h10) begin n_fail++; $display("FAIL stall_hold2 got=%h exp=%h", if0.pc, 32'h10); end
    idle_inputs();
    step();
    n_tests++; if (if0.pc !== 32'h200) begin n_fail++; $display("FAIL pend_release got=%h exp=%h", if0.pc, 32'h200); end
    step();
    n_tests++; if (if0.pc !== 32'h204) begin n_fail++; $display("FAIL pend_after got=%h exp=%h", if0.pc, 32'h204); end
  endtask

  task automatic test_delay_slot();
    do_reset();
    steps(8);
    rv = 1'b1; tgt = 32'h400;
    step();
    n_tests++; if (if1.pc !== 32'h24 || if1.in_delay_slot !== 1'b1) begin n_fail++; $display("FAIL ds_slot got=%h/%b exp=%h/1", if1.pc, if1.in_delay_slot, 32'h24); end
    tgt = 32'h800;
    step();
    n_tests++; if (if1.pc !== 32'h400 || if1.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL ds_target got=%h/%b exp=%h/0", if1.pc, if1.in_delay_slot, 32'h400); end
    idle_inputs();
    step();
    n_tests++; if (if1.pc !== 32'h404) begin n_fail++; $display("FAIL ds_after got=%h exp=%h", if1.pc, 32'h404); end
  endtask

  task automatic test_exc_in_slot();
    do_reset();
    steps(8);
    rv = 1'b1; tgt = 32'h400;
    step();
    rv = 1'b0; exc = 1'b1;
    step();
    n_tests++; if (if1.pc !== 32'h8000_0180) begin n_fail++; $display("FAIL exc_pc got=%h exp=%h", if1.pc, 32'h8000_0180); end
    n_tests++; if (if1.epc !== 32'h20 || if1.epc_bd !== 1'b1) begin n_fail++; $display("FAIL exc_epc got=%h/%b exp=%h/1", if1.epc, if1.epc_bd, 32'h20); end
    n_tests++; if (if1.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL exc_ids got=%b exp=0", if1.in_delay_slot); end
    exc = 1'b0; eret = 1'b1;
    step();
    n_tests++; if (if1.pc !== 32'h20) begin n_fail++; $display("FAIL eret_pc got=%h exp=%h", if1.pc, 32'h20); end
    idle_inputs();
  endtask

  task automatic test_misalign();
    do_reset();
    steps(12);
    rv = 1'b1; tgt = 32'h102;
    step();
    n_tests++; if (if0.misalign_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault got=%b exp=1", if0.misalign_fault); end
    n_tests++; if (if0.badaddr !== 32'h102) begin n_fail++; $display("FAIL mis_bad got=%h exp=%h", if0.badaddr, 32'h102); end
    n_tests++; if (if0.epc !== 32'h30 || if0.epc_bd !== 1'b0) begin n_fail++; $display("FAIL mis_epc got=%h/%b exp=%h/0", if0.epc, if0.epc_bd, 32'h30); end
    n_tests++; if (if0.pc !== 32'h8000_0180) begin n_fail++; $display("FAIL mis_pc got=%h exp=%h", if0.pc, 32'h8000_0180); end
    idle_inputs();
    step();
    n_tests++; if (if0.misalign_fault !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got=%b exp=0", if0.misalign_fault); end
    n_tests++; if (if0.pc !== 32'h8000_0184) begin n_fail++; $display("FAIL mis_next got=%h exp=%h", if0.pc, 32'h8000_0184); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    steps(63);
    n_tests++; if (if2.pc !== 8'hFC || if2.pc_plus_inc !== 8'h00) begin n_fail++; $display("FAIL wrap_pre got=%h/%h exp=fc/00", if2.pc, if2.pc_plus_inc); end
    step();
    n_tests++; if (if2.pc !== 8'h00) begin n_fail++; $display("FAIL wrap got=%h exp=00", if2.pc); end
    step();
    stall = 1'b1; rv = 1'b1; tgt = 32'h40;
    step();
    n_tests++; if (if2.pc !== 8'h04) begin n_fail++; $display("FAIL w_pend_hold got=%h exp=04", if2.pc); end
    idle_inputs();
    rst_n = 1'b0;
    step();
    n_tests++; if (if2.pc !== 8'h00 || if2.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL w_reset got=%h/%b exp=00/0", if2.pc, if2.fetch_valid); end
    rst_n = 1'b1;
    step();
    n_tests++; if (if2.pc !== 8'h04) begin n_fail++; $display("FAIL w_rel1 got=%h exp=04", if2.pc); end
    step();
    n_tests++; if (if2.pc !== 8'h08) begin n_fail++; $display("FAIL w_rel2 got=%h exp=08", if2.pc); end
  endtask

  task automatic test_random();
    m_t          m [3];
    logic [31:0] got [8];
    logic [31:0] exp [8];
    logic [31:0] mask;
    bit          r, st, v, x, e;
    logic [31:0] t;
    string       nm [8] = '{"pc", "pc_plus_inc", "fetch_valid", "in_delay_slot",
                            "epc", "epc_bd", "badaddr", "misalign_fault"};
    for (int k = 0; k < 3; k++) m[k] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      stall = ($urandom_range(0, 99) < 30);
      rv    = ($urandom_range(0, 99) < 25);
      tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      exc   = ($urandom_range(0, 99) < 4);
      eret  = ($urandom_range(0, 99) < 4);
      r = rst_n; st = stall; v = rv; t = tgt; x = exc; e = eret;
      step();
      m[0] = m_step(m[0], 1'b0, 32, 32'h8000_0180, r, st, v, t, x, e);
      m[1] = m_step(m[1], 1'b1, 32, 32'h8000_0180, r, st, v, t, x, e);
      m[2] = m_step(m[2], 1'b0, 8,  32'h0000_0080, r, st, v, t, x, e);
      for (int k = 0; k < 3; k++) begin
        mask = (k == 2) ? 32'hFF : 32'hFFFF_FFFF;
        case (k)
          0: begin got[0] = if0.pc; got[1] = if0.pc_plus_inc; got[2] = 32'(if0.fetch_valid); got[3] = 32'(if0.in_delay_slot);
                   got[4] = if0.epc; got[5] = 32'(if0.epc_bd); got[6] = if0.badaddr; got[7] = 32'(if0.misalign_fault); end
          1: begin got[0] = if1.pc; got[1] = if1.pc_plus_inc; got[2] = 32'(if1.fetch_valid); got[3] = 32'(if1.in_delay_slot);
                   got[4] = if1.epc; got[5] = 32'(if1.epc_bd); got[6] = if1.badaddr; got[7] = 32'(if1.misalign_fault); end
          default: begin got[0] = 32'(if2.pc); got[1] = 32'(if2.pc_plus_inc); got[2] = 32'(if2.fetch_valid); got[3] = 32'(if2.in_delay_slot);
                   got[4] = 32'(if2.epc); got[5] = 32'(if2.epc_bd); got[6] = 32'(if2.badaddr); got[7] = 32'(if2.misalign_fault); end
        endcase
        exp[0] = m[k].pc;  exp[1] = (m[k].pc + 32'd4) & mask;  exp[2] = 32'(m[k].fv);  exp[3] = 32'(m[k].slot);
        exp[4] = m[k].epc; exp[5] = 32'(m[k].bd);  exp[6] = m[k].bad;  exp[7] = 32'(m[k].fault);
        for (int f = 0; f < 8; f++) begin
          n_tests++;
          if (got[f] !== exp[f]) begin
            n_fail++;
            $display("FAIL rnd_%s dut%0d cyc%0d got=%h exp=%h", nm[f], k, cyc, got[f], exp[f]);
          end
        end
      end
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_stall_redirect();
    test_delay_slot();
    test_exc_in_slot();
    test_misalign();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the plain PC register.
- Sits at the head of the fetch stage and holds the current fetch address.
- Adds, beyond sequential increment: pipeline stall, branch/jump redirect with optional MIPS delay slot, redirects captured while stalled, exception vectoring with EPC/BadVAddr capture, and ERET return.

Parameters:
- WIDTH, 32: address width in bits.
- INC, 4: sequential increment (bytes per instruction).
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180: PC value loaded on an exception or a misaligned redirect.
- DELAY_SLOT, 0: 0 = redirect takes effect immediately; 1 = one architectural delay slot.
- ALIGN_BITS, 2: number of low target bits that must be zero.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-low reset (asserted when 0).
- stall, in, 1: hold the PC and the pending state.
- redirect_valid, in, 1: branch taken or jump this cycle.
- redirect_target, in, WIDTH: redirect destination.
- exc_req, in, 1: take an exception.
- eret, in, 1: return from exception.
- pc, out, WIDTH: current fetch address (registered).
- pc_plus_inc, out, WIDTH: pc + INC (combinational, mod 2^WIDTH).
- fetch_valid, out, 1: pc holds a fetchable address.
- in_delay_slot, out, 1: pc is a delay-slot instruction.
- epc, out, WIDTH: exception PC.
- epc_bd, out, 1: the exception was taken in a delay slot.
- badaddr, out, WIDTH: last misaligned target.
- misalign_fault, out, 1: one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc=RESET_VECTOR; epc=0; epc_bd=0; badaddr=0.
  - misalign_fault=0; fetch_valid=0; in_delay_slot=0.
  - state=RUN; pend_target=0.
- fetch_valid: 1 from the first edge with reset==1 onward.
- States: RUN, PEND (redirect captured during a stall), DELAY (delay slot being fetched; target held).
- Per-edge priority when out of reset: exc_req > misaligned redirect > eret > stall > redirect > sequential.
- Exception (exc_req=1, ignores stall):
  - pc<=EXC_VECTOR; state<=RUN; any pending or delay target is discarded.
  - If state==DELAY: epc<=pc-INC and epc_bd<=1.
  - Otherwise: epc<=pc and epc_bd<=0.
- Misaligned redirect (redirect_valid=1 and redirect_target[ALIGN_BITS-1:0]!=0, accepted in RUN or PEND, ignores stall):
  - misalign_fault<=1 for one cycle.
  - badaddr<=redirect_target; epc<=pc; epc_bd<=0.
  - pc<=EXC_VECTOR; state<=RUN.
- ERET (eret=1): pc<=epc; state<=RUN; pending state cleared; ignores stall.
- DELAY_SLOT=0:
  - RUN, !stall, redirect: pc<=target.
  - RUN, stall, redirect: pend_target<=target; state<=PEND; pc holds.
  - PEND, stall: hold; a new redirect overwrites pend_target.
  - PEND, !stall: pc<=pend_target; state<=RUN. A redirect presented in this same cycle wins over pend_target.
- DELAY_SLOT=1:
  - RUN, !stall, redirect: pc<=pc+INC; pend_target<=target; state<=DELAY; in_delay_slot<=1.
  - RUN, stall, redirect: capture into PEND.
  - PEND, !stall: behaves as the RUN/!stall/redirect case using pend_target.
  - DELAY, !stall: pc<=pend_target; state<=RUN; in_delay_slot<=0.
  - DELAY, stall: hold.
  - Redirects arriving in DELAY are ignored, including misaligned ones.
- No event, !stall: pc<=pc+INC. Arithmetic wraps modulo 2^WIDTH (all-ones minus INC+1 wraps to low addresses; no flag).
- Stall with no redirect: every register holds.
- Latency: one edge from an accepted event to the pc update. pc is never combinationally driven by inputs.

Test Plan:
- Reset/sequential: hold reset=0 two cycles, then release → pc=0, fetch_valid=0 during reset; 0x4, 0x8, 0xC on successive edges; fetch_valid=1 after the first edge with reset=1.
- Stall-captured redirect (DELAY_SLOT=0): pc=0x10, stall=1, redirect 0x100 then 0x200 → pc holds 0x10 two cycles; stall=0 → pc=0x200, then 0x204.
- Delay slot (DELAY_SLOT=1): pc=0x20, redirect 0x400 → pc=0x24 with in_delay_slot=1, then pc=0x400; a redirect 0x800 presented during the slot is ignored.
- Exception in delay slot: as above, exc_req asserted while pc=0x24 → pc=0x80000180, epc=0x20, epc_bd=1; eret → pc=0x20.
- Misaligned redirect: pc=0x30, redirect 0x102 → misalign_fault=1 for one cycle, badaddr=0x102, epc=0x30, pc=0x80000180.
- Wrap and mid-operation reset (WIDTH=8, INC=4): pc=0xFC → 0x00. Assert reset while in PEND → pc=RESET_VECTOR, state RUN, no stale redirect after release.
